// File: rtl/audio_cfg_pkg.sv
// Shared definitions for the audio configuration reload sequencer.
//   seq_state_e : sequencer states; encodings are read by the CPU status register
//   ld_mode_e   : which memory the word loader is currently streaming into
//   ARST_CYCLES : cycles the write-pointer resets are held high
//   CHECK_CYCLES: settle cycles before sampling the pointer-zero status bits
package audio_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_MUTE   = 4'd1,
        ST_ARST   = 4'd2,
        ST_COEF   = 4'd3,
        ST_EQ     = 4'd4,
        ST_CHECK  = 4'd5,
        ST_UNMUTE = 4'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        LD_NONE = 2'd0,
        LD_COEF = 2'd1,
        LD_EQ   = 2'd2
    } ld_mode_e;

    localparam int ARST_CYCLES  = 2;
    localparam int CHECK_CYCLES = 2;
    localparam int TIMER_W      = 8;

endpackage

// File: rtl/audio_cfg_sequencer_loader.sv
// Word loader shared by the coefficient and EQ phases.
// Owns the ready/accept handshake, the one-cycle write register and the
// filter/tap counters.
//   clk_i, reset_i      : clock, async active-high reset
//   init_i              : start accepted; latch cpt_i and rewind the counters
//   cpt_i               : coefficients per filter
//   mode_i              : LD_COEF / LD_EQ while streaming, LD_NONE otherwise
//   clear_i             : abort; drop any pending write strobe
//   word_valid_i/data_i : incoming word stream
//   word_ready_o        : word is taken this cycle when valid
//   last_o              : the accepted word is the last one of the current mode
//   coef_* / eq_*       : write strobes, index and data towards the memories
module cfg_word_loader
    import audio_cfg_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int TAP_CNT_W   = 9
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 init_i,
    input  logic [TAP_CNT_W-1:0] cpt_i,
    input  ld_mode_e             mode_i,
    input  logic                 clear_i,
    input  logic                 word_valid_i,
    input  logic [15:0]          word_data_i,
    output logic                 word_ready_o,
    output logic                 last_o,
    output logic                 coef_wr_en_o,
    output logic [5:0]           coef_select_o,
    output logic [7:0]           coef_wr_lsb_o,
    output logic [7:0]           coef_wr_msb_o,
    output logic                 eq_wr_en_o,
    output logic [3:0]           eq_select_o,
    output logic [7:0]           eq_wr_lsb_o,
    output logic [7:0]           eq_wr_msb_o
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_FILTERS - 1);

    logic [TAP_CNT_W-1:0] cpt_q, cpt_d;
    logic [TAP_CNT_W-1:0] tap_q, tap_d;
    logic [5:0]           idx_q, idx_d;
    logic                 pend_q, pend_d;
    ld_mode_e             pend_mode_q, pend_mode_d;
    logic [5:0]           coef_sel_q, coef_sel_d;
    logic [15:0]          coef_data_q, coef_data_d;
    logic [3:0]           eq_sel_q, eq_sel_d;
    logic [15:0]          eq_data_q, eq_data_d;

    logic accept;
    logic tap_end;
    logic idx_end;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cpt_q       <= '0;
            tap_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_mode_q <= LD_NONE;
            coef_sel_q  <= '0;
            coef_data_q <= '0;
            eq_sel_q    <= '0;
            eq_data_q   <= '0;
        end else begin
            cpt_q       <= cpt_d;
            tap_q       <= tap_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            coef_sel_q  <= coef_sel_d;
            coef_data_q <= coef_data_d;
            eq_sel_q    <= eq_sel_d;
            eq_data_q   <= eq_data_d;
        end
    end

    // Ready drops in the cycle after an accept, which caps the rate at one
    // word every two cycles and keeps the write strobe a single-cycle pulse.
    always_comb begin
        word_ready_o = (mode_i != LD_NONE) && !pend_q;
        accept       = word_valid_i && word_ready_o;
        tap_end      = (tap_q == '0);
        idx_end      = (idx_q == LAST_IDX);
        last_o       = accept && idx_end && ((mode_i == LD_EQ) || tap_end);
    end

    always_comb begin
        cpt_d       = cpt_q;
        tap_d       = tap_q;
        idx_d       = idx_q;
        pend_d      = accept && !clear_i;
        pend_mode_d = pend_mode_q;
        coef_sel_d  = coef_sel_q;
        coef_data_d = coef_data_q;
        eq_sel_d    = eq_sel_q;
        eq_data_d   = eq_data_q;

        if (init_i) begin
            cpt_d = cpt_i;
            tap_d = cpt_i - 1'b1;
            idx_d = '0;
        end else if (accept) begin
            pend_mode_d = mode_i;
            if (mode_i == LD_COEF) begin
                coef_sel_d  = idx_q;
                coef_data_d = word_data_i;
                if (tap_end) begin
                    tap_d = cpt_q - 1'b1;
                    idx_d = idx_end ? 6'd0 : idx_q + 6'd1;
                end else begin
                    tap_d = tap_q - 1'b1;
                end
            end else begin
                eq_sel_d  = idx_q[3:0];
                eq_data_d = word_data_i;
                idx_d     = idx_end ? 6'd0 : idx_q + 6'd1;
            end
        end
    end

    assign coef_wr_en_o  = pend_q && (pend_mode_q == LD_COEF);
    assign coef_select_o = coef_sel_q;
    assign coef_wr_msb_o = coef_data_q[15:8];
    assign coef_wr_lsb_o = coef_data_q[7:0];
    assign eq_wr_en_o    = pend_q && (pend_mode_q == LD_EQ);
    assign eq_select_o   = eq_sel_q;
    assign eq_wr_msb_o   = eq_data_q[15:8];
    assign eq_wr_lsb_o   = eq_data_q[7:0];

endmodule

// File: rtl/audio_cfg_sequencer.sv
// Reload sequencer for the FIR coefficient and EQ gain memories.
// Mutes audio on a frame boundary, resets the write pointers, streams the
// words in through cfg_word_loader, verifies both pointers wrapped and
// re-enables audio on a frame boundary.
//   clk, reset           : clock, async active-high reset
//   run_req              : CPU audio-enable request
//   start, abort         : one-cycle command strobes
//   coefs_per_tap        : coefficients per filter, latched at start
//   frame_stb            : frame boundary strobe
//   word_valid/data/ready: load word stream
//   audio_enable         : audio datapath enable
//   coef_* / eq_*        : memory write interface
//   fir_pntr_zero, eq_wr_addr_zero : pointer wrap status
//   busy, done, error, state       : status towards the CPU
//
// state     | meaning
// IDLE      | audio follows run_req; waiting for start
// MUTE      | drop audio on a frame strobe, then drain MUTE_FRAMES frames
// ARST      | both write-pointer resets held high
// COEF      | streaming FIR coefficients, filter by filter
// EQ        | streaming EQ gains
// CHECK     | settle, then verify both pointers wrapped to zero
// UNMUTE    | re-enable audio on the next frame strobe
module audio_cfg_sequencer
    import audio_cfg_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int TAP_CNT_W   = 9,
    parameter int MUTE_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TAP_CNT_W-1:0] coefs_per_tap,
    input  logic                 frame_stb,
    input  logic                 word_valid,
    input  logic [15:0]          word_data,
    output logic                 word_ready,
    output logic                 audio_enable,
    output logic                 coef_addr_rst,
    output logic                 coef_wr_en,
    output logic [5:0]           coef_select,
    output logic [7:0]           coef_wr_lsb,
    output logic [7:0]           coef_wr_msb,
    output logic                 eq_addr_rst,
    output logic                 eq_wr_en,
    output logic [3:0]           eq_select,
    output logic [7:0]           eq_wr_lsb,
    output logic [7:0]           eq_wr_msb,
    input  logic                 fir_pntr_zero,
    input  logic                 eq_wr_addr_zero,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [3:0]           state
);

    seq_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               drop_q, drop_d;
    logic               audio_q, audio_d;
    logic               error_q, error_d;
    logic               lock_q, lock_d;
    logic               done_q, done_d;

    ld_mode_e ld_mode;
    logic     ld_last;
    logic     start_ok;
    logic     abort_hit;

    assign start_ok  = start && (state_q == ST_IDLE);
    assign abort_hit = abort && ((state_q == ST_MUTE) || (state_q == ST_ARST) ||
                                 (state_q == ST_COEF) || (state_q == ST_EQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            drop_q  <= 1'b0;
            audio_q <= 1'b0;
            error_q <= 1'b0;
            lock_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            audio_q <= audio_d;
            error_q <= error_d;
            lock_q  <= lock_d;
            done_q  <= done_d;
        end
    end

    // lock_q keeps audio off after a failure that left the memories in an
    // unknown state (abort, pointer check). A zero tap count is rejected
    // before anything is touched, so it flags error without muting.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = drop_q;
        audio_d = audio_q;
        error_d = error_q;
        lock_d  = lock_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    lock_d  = 1'b0;
                    if (coefs_per_tap == '0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_MUTE;
                        timer_d = TIMER_W'(MUTE_FRAMES - 1);
                        drop_d  = 1'b0;
                    end
                end
                audio_d = run_req && !lock_d;
            end
            ST_MUTE: begin
                if (frame_stb) begin
                    if (!drop_q) begin
                        drop_d  = 1'b1;
                        audio_d = 1'b0;
                    end else if (timer_q == '0) begin
                        state_d = ST_ARST;
                        timer_d = TIMER_W'(ARST_CYCLES - 1);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            ST_ARST: begin
                if (timer_q == '0) state_d = ST_COEF;
                else               timer_d = timer_q - 1'b1;
            end
            ST_COEF: begin
                if (ld_last) state_d = ST_EQ;
            end
            ST_EQ: begin
                if (ld_last) begin
                    state_d = ST_CHECK;
                    timer_d = TIMER_W'(CHECK_CYCLES);
                end
            end
            ST_CHECK: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (fir_pntr_zero && eq_wr_addr_zero) begin
                    state_d = ST_UNMUTE;
                end else begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    lock_d  = 1'b1;
                end
            end
            ST_UNMUTE: begin
                if (frame_stb) begin
                    audio_d = run_req;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_hit) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            lock_d  = 1'b1;
            audio_d = 1'b0;
        end
    end

    always_comb begin
        ld_mode = LD_NONE;
        if (state_q == ST_COEF)    ld_mode = LD_COEF;
        else if (state_q == ST_EQ) ld_mode = LD_EQ;
        busy          = (state_q != ST_IDLE);
        coef_addr_rst = (state_q == ST_ARST);
        eq_addr_rst   = (state_q == ST_ARST);
    end

    cfg_word_loader #(
        .NUM_FILTERS (NUM_FILTERS),
        .TAP_CNT_W   (TAP_CNT_W)
    ) u_loader (
        .clk_i         (clk),
        .reset_i       (reset),
        .init_i        (start_ok),
        .cpt_i         (coefs_per_tap),
        .mode_i        (ld_mode),
        .clear_i       (abort_hit),
        .word_valid_i  (word_valid),
        .word_data_i   (word_data),
        .word_ready_o  (word_ready),
        .last_o        (ld_last),
        .coef_wr_en_o  (coef_wr_en),
        .coef_select_o (coef_select),
        .coef_wr_lsb_o (coef_wr_lsb),
        .coef_wr_msb_o (coef_wr_msb),
        .eq_wr_en_o    (eq_wr_en),
        .eq_select_o   (eq_select),
        .eq_wr_lsb_o   (eq_wr_lsb),
        .eq_wr_msb_o   (eq_wr_msb)
    );

    assign audio_enable = audio_q;
    assign error        = error_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_audio_cfg_sequencer.sv
`timescale 1ns/1ps
module tb_audio_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req;
    logic        start;
    logic        abort;
    logic [8:0]  coefs_per_tap;
    logic        frame_stb;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_ready;
    logic        audio_enable;
    logic        coef_addr_rst;
    logic        coef_wr_en;
    logic [5:0]  coef_select;
    logic [7:0]  coef_wr_lsb;
    logic [7:0]  coef_wr_msb;
    logic        eq_addr_rst;
    logic        eq_wr_en;
    logic [3:0]  eq_select;
    logic [7:0]  eq_wr_lsb;
    logic [7:0]  eq_wr_msb;
    logic        fir_pntr_zero;
    logic        eq_wr_addr_zero;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    int n_coef = 0;
    int n_eq   = 0;
    int n_done = 0;
    int coef_log  [128];
    int coef_dlog [128];
    int eq_log    [128];
    int eq_dlog   [128];

    audio_cfg_sequencer #(
        .NUM_FILTERS (4),
        .TAP_CNT_W   (9),
        .MUTE_FRAMES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run_req         (run_req),
        .start           (start),
        .abort           (abort),
        .coefs_per_tap   (coefs_per_tap),
        .frame_stb       (frame_stb),
        .word_valid      (word_valid),
        .word_data       (word_data),
        .word_ready      (word_ready),
        .audio_enable    (audio_enable),
        .coef_addr_rst   (coef_addr_rst),
        .coef_wr_en      (coef_wr_en),
        .coef_select     (coef_select),
        .coef_wr_lsb     (coef_wr_lsb),
        .coef_wr_msb     (coef_wr_msb),
        .eq_addr_rst     (eq_addr_rst),
        .eq_wr_en        (eq_wr_en),
        .eq_select       (eq_select),
        .eq_wr_lsb       (eq_wr_lsb),
        .eq_wr_msb       (eq_wr_msb),
        .fir_pntr_zero   (fir_pntr_zero),
        .eq_wr_addr_zero (eq_wr_addr_zero),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // frame strobe: one cycle in every six
    initial begin
        int fcnt;
        fcnt = 0;
        frame_stb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fcnt++;
            frame_stb = (fcnt % 6 == 0);
        end
    end

    // word source: restarts at 0x0100 whenever word_valid is low
    initial begin
        logic acc;
        word_data = 16'h0100;
        forever begin
            @(negedge clk);
            acc = word_valid && word_ready && !reset;
            @(posedge clk);
            #1;
            if (!word_valid) word_data = 16'h0100;
            else if (acc)    word_data = word_data + 16'd1;
        end
    end

    // write monitor: data latency, mutual exclusion, accept gap, done on frame
    initial begin
        logic        prev_fs;
        logic        have_acc;
        logic [15:0] last_word;
        int          cyc;
        int          last_acc_cyc;
        prev_fs = 1'b0;
        have_acc = 1'b0;
        last_word = '0;
        cyc = 0;
        last_acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (coef_wr_en) begin
                    check("coef_data", 32'({coef_wr_msb, coef_wr_lsb}), 32'(last_word));
                    check("mutex_coef_audio", 32'(audio_enable), 0);
                    check("single_strobe", 32'(eq_wr_en), 0);
                    coef_log[n_coef % 128]  = int'(coef_select);
                    coef_dlog[n_coef % 128] = int'({coef_wr_msb, coef_wr_lsb});
                    n_coef++;
                end
                if (eq_wr_en) begin
                    check("eq_data", 32'({eq_wr_msb, eq_wr_lsb}), 32'(last_word));
                    check("mutex_eq_audio", 32'(audio_enable), 0);
                    eq_log[n_eq % 128]  = int'(eq_select);
                    eq_dlog[n_eq % 128] = int'({eq_wr_msb, eq_wr_lsb});
                    n_eq++;
                end
                if (done) begin
                    check("done_on_frame", 32'(prev_fs), 1);
                    n_done++;
                end
                if (word_valid && word_ready) begin
                    if (have_acc) check("accept_gap", 32'((cyc - last_acc_cyc) >= 2), 1);
                    have_acc     = 1'b1;
                    last_acc_cyc = cyc;
                    last_word    = word_data;
                end
            end
            prev_fs = frame_stb;
            cyc++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (state != 4'd0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state == 4'd0), 1);
        @(negedge clk);
    endtask

    initial begin
        int b_coef, b_eq, b_done, k;
        logic stayed;

        reset = 1'b1;
        run_req = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        coefs_per_tap = 9'd3;
        word_valid = 1'b0;
        fir_pntr_zero = 1'b1;
        eq_wr_addr_zero = 1'b1;

        #12;
        check("rst_state", 32'(state), 0);
        check("rst_audio", 32'(audio_enable), 0);
        check("rst_ready", 32'(word_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr_rst", 32'({coef_addr_rst, eq_addr_rst}), 0);
        check("rst_strobes", 32'({coef_wr_en, eq_wr_en}), 0);

        @(negedge clk);
        reset = 1'b0;
        run_req = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_audio_follows_run", 32'(audio_enable), 1);
        check("idle_ready_low", 32'(word_ready), 0);

        // Test 1: full reload, 4 filters x 3 taps, then 4 gains
        b_coef = n_coef; b_eq = n_eq; b_done = n_done;
        word_valid = 1'b1;
        coefs_per_tap = 9'd3;
        pulse_start();
        coefs_per_tap = 9'd7;
        check("t1_busy", 32'(busy), 1);
        check("t1_state_mute", 32'(state), 1);
        wait_idle("t1_timeout", 600);
        check("t1_coef_count", 32'(n_coef - b_coef), 12);
        for (int i = 0; i < 12; i++) check("t1_coef_select", 32'(coef_log[(b_coef + i) % 128]), 32'(i / 3));
        check("t1_coef_first_data", 32'(coef_dlog[b_coef % 128]), 32'h0100);
        check("t1_coef_last_data", 32'(coef_dlog[(b_coef + 11) % 128]), 32'h010B);
        check("t1_eq_count", 32'(n_eq - b_eq), 4);
        for (int i = 0; i < 4; i++) check("t1_eq_select", 32'(eq_log[(b_eq + i) % 128]), 32'(i));
        check("t1_eq_last_data", 32'(eq_dlog[(b_eq + 3) % 128]), 32'h010F);
        check("t1_done_count", 32'(n_done - b_done), 1);
        check("t1_audio_back", 32'(audio_enable), 1);
        check("t1_error", 32'(error), 0);
        check("t1_busy_clear", 32'(busy), 0);
        word_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", 32'(error), 0);

        // Test 2: EQ pointer did not wrap
        b_coef = n_coef; b_done = n_done;
        word_valid = 1'b1;
        coefs_per_tap = 9'd3;
        eq_wr_addr_zero = 1'b0;
        pulse_start();
        wait_idle("t2_timeout", 600);
        check("t2_error", 32'(error), 1);
        check("t2_state", 32'(state), 0);
        check("t2_no_done", 32'(n_done - b_done), 0);
        check("t2_coef_count", 32'(n_coef - b_coef), 12);
        repeat (3) @(negedge clk);
        check("t2_audio_held_off", 32'(audio_enable), 0);
        eq_wr_addr_zero = 1'b1;
        word_valid = 1'b0;
        @(negedge clk);

        // Test 3: abort right after the 5th coefficient write strobe
        b_coef = n_coef;
        word_valid = 1'b1;
        pulse_start();
        check("t3_error_cleared", 32'(error), 0);
        k = 0;
        for (int i = 0; i < 600 && k < 5; i++) begin
            if (coef_wr_en) k++;
            if (k < 5) @(negedge clk);
        end
        check("t3_reach_5th", 32'(k), 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_strobes_off", 32'({coef_wr_en, eq_wr_en}), 0);
        check("t3_error", 32'(error), 1);
        check("t3_state", 32'(state), 0);
        check("t3_busy", 32'(busy), 0);
        check("t3_ready", 32'(word_ready), 0);
        @(negedge clk);
        check("t3_coef_count", 32'(n_coef - b_coef), 5);
        word_valid = 1'b0;
        @(negedge clk);

        // Test 4: async reset mid-COEF, then a 1-tap reload
        word_valid = 1'b1;
        coefs_per_tap = 9'd3;
        pulse_start();
        k = 0;
        for (int i = 0; i < 600 && k < 2; i++) begin
            if (coef_wr_en) k++;
            if (k < 2) @(negedge clk);
        end
        check("t4_reach_coef", 32'(k), 2);
        #2;
        reset = 1'b1;
        #1;
        check("t4_rst_strobe", 32'(coef_wr_en), 0);
        check("t4_rst_select", 32'(coef_select), 0);
        check("t4_rst_data", 32'({coef_wr_msb, coef_wr_lsb}), 0);
        check("t4_rst_state", 32'(state), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_ready", 32'(word_ready), 0);
        check("t4_rst_error", 32'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        b_coef = n_coef; b_eq = n_eq; b_done = n_done;
        word_valid = 1'b1;
        coefs_per_tap = 9'd1;
        pulse_start();
        wait_idle("t4_timeout", 600);
        check("t4_coef_count", 32'(n_coef - b_coef), 4);
        for (int i = 0; i < 4; i++) check("t4_coef_select", 32'(coef_log[(b_coef + i) % 128]), 32'(i));
        check("t4_eq_count", 32'(n_eq - b_eq), 4);
        check("t4_done_count", 32'(n_done - b_done), 1);
        check("t4_audio", 32'(audio_enable), 1);
        word_valid = 1'b0;
        @(negedge clk);

        // Test 5: zero tap count is rejected without muting
        coefs_per_tap = 9'd0;
        check("t5_audio_before", 32'(audio_enable), 1);
        pulse_start();
        check("t5_error", 32'(error), 1);
        check("t5_state", 32'(state), 0);
        check("t5_busy", 32'(busy), 0);
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!audio_enable) stayed = 1'b0;
        end
        check("t5_audio_never_dropped", 32'(stayed), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
